// File: rtl/mem_test_pkg.sv
// Shared types for the memory sweep sequencer: FSM state encoding.
package mem_test_pkg;
  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    IDLE,
    CHECK,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    WR_WAIT,
    ADVANCE,
    FINISH
  } seq_state_t;
endpackage

// File: rtl/mem_sweep_sequencer_if.sv
// Start/address/size/done control bundle between the sweep sequencer and the AXI read/write masters.
interface mem_sweep_sequencer_if #(
  parameter int ADDR_W = 64,
  parameter int XFER_W = 32
) ();
  import mem_test_pkg::*;

  logic              rd_start;
  logic [ADDR_W-1:0] rd_addr;
  logic [XFER_W-1:0] rd_size;
  logic              rd_done;
  logic              wr_start;
  logic [ADDR_W-1:0] wr_addr;
  logic [XFER_W-1:0] wr_size;
  logic              wr_done;

  modport master (
    output rd_start, rd_addr, rd_size,
    input  rd_done,
    output wr_start, wr_addr, wr_size,
    input  wr_done
  );

  modport slave (
    input  rd_start, rd_addr, rd_size,
    output rd_done,
    input  wr_start, wr_addr, wr_size,
    output wr_done
  );
endinterface

// File: rtl/mem_sweep_sequencer.sv
// Sequences read-then-write steps across a memory region for a programmed number of passes,
// tracking completed steps, passes and busy cycles.
module mem_sweep_sequencer
  import mem_test_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_PASS_WIDTH       = 16,
  parameter int C_CYCLE_CNT_WIDTH  = 64
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          ap_start,
  output logic                          ap_done,
  output logic                          busy,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] rd_base,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] wr_base,
  input  logic [31:0]                   addr_increment,
  input  logic [31:0]                   mem_max_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  xfer_size,
  input  logic [C_PASS_WIDTH-1:0]       num_passes,
  output logic [31:0]                   step_count,
  output logic [C_PASS_WIDTH-1:0]       pass_count,
  output logic [C_CYCLE_CNT_WIDTH-1:0]  cycle_count,
  mem_sweep_sequencer_if.master         m_ctrl
);
  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int XW    = C_XFER_SIZE_WIDTH;
  localparam int PW    = C_PASS_WIDTH;
  localparam int CW    = C_CYCLE_CNT_WIDTH;
  // Two guard bits so offset+increment+xfer never wraps inside the compare.
  localparam int CMP_W = ((XW > 32) ? XW : 32) + 2;

  seq_state_t    state_q, state_d;
  logic [31:0]   offset_q, offset_d;
  logic [AW-1:0] rd_base_q, rd_base_d, wr_base_q, wr_base_d;
  logic [31:0]   incr_q, incr_d, max_q, max_d;
  logic [XW-1:0] xfer_q, xfer_d;
  logic [PW-1:0] passes_q, passes_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [31:0]   step_q, step_d;
  logic [PW-1:0] pass_q, pass_d;
  logic [CW-1:0] cyc_q, cyc_d;

  logic [CMP_W-1:0] cur_end, next_off, next_end;
  logic [PW:0]      pass_inc, pass_target;
  logic             last_pass, busy_w;

  assign busy_w = state_q inside {CHECK, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, ADVANCE};

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    rd_base_d   = rd_base_q;
    wr_base_d   = wr_base_q;
    incr_d      = incr_q;
    max_d       = max_q;
    xfer_d      = xfer_q;
    passes_d    = passes_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    step_d      = step_q;
    pass_d      = pass_q;
    cyc_d       = cyc_q;
    cur_end     = CMP_W'(offset_q) + CMP_W'(xfer_q);
    next_off    = CMP_W'(offset_q) + CMP_W'(incr_q);
    next_end    = next_off + CMP_W'(xfer_q);
    pass_inc    = {1'b0, pass_q} + (PW+1)'(1);
    pass_target = (passes_q == '0) ? (PW+1)'(1) : {1'b0, passes_q};
    last_pass   = (pass_inc == pass_target);

    if (busy_w && (cyc_q != '1)) begin
      cyc_d = cyc_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (ap_start) begin
          rd_base_d = rd_base;
          wr_base_d = wr_base;
          incr_d    = addr_increment;
          max_d     = mem_max_addr;
          xfer_d    = xfer_size;
          passes_d  = num_passes;
          offset_d  = '0;
          step_d    = '0;
          pass_d    = '0;
          cyc_d     = '0;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if ((xfer_q == '0) || (cur_end > CMP_W'(max_q))) begin
          state_d = FINISH;
        end else begin
          // Loaded on entry so the address is already valid alongside rd_start.
          rd_addr_d = rd_base_q + AW'(offset_q);
          state_d   = RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (m_ctrl.rd_done) begin
          wr_addr_d = wr_base_q + AW'(offset_q);
          state_d   = WR_ISSUE;
        end
      end
      WR_ISSUE: state_d = WR_WAIT;
      WR_WAIT: begin
        if (m_ctrl.wr_done) begin
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        step_d = step_q + 32'd1;
        if ((incr_q == '0) || (next_end > CMP_W'(max_q))) begin
          pass_d   = pass_inc[PW-1:0];
          offset_d = '0;
          state_d  = last_pass ? FINISH : CHECK;
        end else begin
          offset_d = next_off[31:0];
          state_d  = CHECK;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      offset_q  <= '0;
      rd_base_q <= '0;
      wr_base_q <= '0;
      incr_q    <= '0;
      max_q     <= '0;
      xfer_q    <= '0;
      passes_q  <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      step_q    <= '0;
      pass_q    <= '0;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      rd_base_q <= rd_base_d;
      wr_base_q <= wr_base_d;
      incr_q    <= incr_d;
      max_q     <= max_d;
      xfer_q    <= xfer_d;
      passes_q  <= passes_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      step_q    <= step_d;
      pass_q    <= pass_d;
      cyc_q     <= cyc_d;
    end
  end

  // Pulses are masked while reset is held so nothing launches in the reset cycle.
  assign ap_done         = (state_q == FINISH) && !areset;
  assign busy            = busy_w;
  assign m_ctrl.rd_start = (state_q == RD_ISSUE) && !areset;
  assign m_ctrl.wr_start = (state_q == WR_ISSUE) && !areset;
  assign m_ctrl.rd_addr  = rd_addr_q;
  assign m_ctrl.wr_addr  = wr_addr_q;
  assign m_ctrl.rd_size  = xfer_q;
  assign m_ctrl.wr_size  = xfer_q;
  assign step_count      = step_q;
  assign pass_count      = pass_q;
  assign cycle_count     = cyc_q;
endmodule

// File: tb/tb_mem_sweep_sequencer.sv
// Scoreboard bench for mem_sweep_sequencer: expected addresses and completion results are queued
// when a run is launched and a monitor compares them as the DUT pulses rd_start/wr_start/ap_done.
module tb_mem_sweep_sequencer;
  typedef struct {
    logic [31:0] step;
    logic [15:0] pass;
    logic [63:0] cyc;
  } done_t;

  logic        clk = 1'b0;
  logic        areset, ap_start, ap_done, busy;
  logic [63:0] rd_base, wr_base;
  logic [31:0] addr_increment, mem_max_addr, xfer_size;
  logic [15:0] num_passes;
  logic [31:0] step_count;
  logic [15:0] pass_count;
  logic [63:0] cycle_count;

  always #5 clk = ~clk;

  mem_sweep_sequencer_if #(.ADDR_W(64), .XFER_W(32)) ctrl ();

  mem_sweep_sequencer dut (
    .aclk(clk), .areset(areset), .ap_start(ap_start), .ap_done(ap_done), .busy(busy),
    .rd_base(rd_base), .wr_base(wr_base), .addr_increment(addr_increment),
    .mem_max_addr(mem_max_addr), .xfer_size(xfer_size), .num_passes(num_passes),
    .step_count(step_count), .pass_count(pass_count), .cycle_count(cycle_count),
    .m_ctrl(ctrl)
  );

  logic [63:0] exp_rd[$];
  logic [63:0] exp_wr[$];
  done_t       exp_done[$];
  int          total = 0;
  int          bad = 0;
  int          cur_lat = 1;
  logic [31:0] cur_xfer = '0;
  logic [63:0] last_rd = '0;
  bit          spur = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_event(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // Read/write master model: done arrives cur_lat cycles after the start pulse.
  initial begin
    int rd_cnt = 0;
    int wr_cnt = 0;
    ctrl.rd_done = 1'b0;
    ctrl.wr_done = 1'b0;
    forever begin
      @(negedge clk);
      ctrl.rd_done = 1'b0;
      ctrl.wr_done = 1'b0;
      if (areset) begin
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        if (ctrl.rd_start) rd_cnt = cur_lat;
        else if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin
            ctrl.rd_done = 1'b1;
            check("rd_addr_hold", ctrl.rd_addr, last_rd);
          end else if (spur && rd_cnt == cur_lat - 1) begin
            ctrl.wr_done = 1'b1;
          end
        end
        if (ctrl.wr_start) wr_cnt = cur_lat;
        else if (wr_cnt > 0) begin
          wr_cnt--;
          if (wr_cnt == 0) ctrl.wr_done = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  initial begin
    logic [63:0] e;
    done_t d;
    forever begin
      @(negedge clk);
      if (ctrl.rd_start) begin
        if (exp_rd.size() == 0) flag_event("rd_start_extra");
        else begin
          e = exp_rd.pop_front();
          check("rd_addr", ctrl.rd_addr, e);
          check("rd_size", 64'(ctrl.rd_size), 64'(cur_xfer));
          last_rd = e;
        end
      end
      if (ctrl.wr_start) begin
        if (exp_wr.size() == 0) flag_event("wr_start_extra");
        else begin
          e = exp_wr.pop_front();
          check("wr_addr", ctrl.wr_addr, e);
          check("wr_size", 64'(ctrl.wr_size), 64'(cur_xfer));
        end
      end
      if (ap_done) begin
        if (exp_done.size() == 0) flag_event("ap_done_extra");
        else begin
          d = exp_done.pop_front();
          check("step_count", 64'(step_count), 64'(d.step));
          check("pass_count", 64'(pass_count), 64'(d.pass));
          check("cycle_count", cycle_count, d.cyc);
          check("busy_at_done", 64'(busy), 64'd0);
          $display("run done: steps=%0d passes=%0d cycles=%0d", step_count, pass_count, cycle_count);
        end
      end
    end
  end

  task automatic push_sweep(input logic [63:0] rb, input logic [63:0] wb, input int passes,
                            input int npts, input logic [31:0] stride);
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k < npts; k++) begin
        exp_rd.push_back(rb + 64'(k) * 64'(stride));
        exp_wr.push_back(wb + 64'(k) * 64'(stride));
      end
    end
  endtask

  // Launches one run from a negedge and waits (bounded) for ap_done.
  task automatic run(input logic [63:0] rb, input logic [63:0] wb, input logic [31:0] inc,
                     input logic [31:0] mx, input logic [31:0] xf, input logic [15:0] np,
                     input int lat, input int exp_n, input int poke);
    int n;
    rd_base = rb; wr_base = wb; addr_increment = inc; mem_max_addr = mx;
    xfer_size = xf; num_passes = np; cur_lat = lat; cur_xfer = xf;
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    n = 1;
    while (!ap_done && n < 600) begin
      @(negedge clk);
      n++;
      if (poke > 0 && n == poke) ap_start = 1'b1;
      if (poke > 0 && n == poke + 3) ap_start = 1'b0;
    end
    if (!ap_done) flag_event("ap_done_timeout");
    else check("done_latency", 64'(n), 64'(exp_n));
    ap_start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1; ap_start = 1'b0;
    rd_base = '0; wr_base = '0; addr_increment = '0; mem_max_addr = '0;
    xfer_size = '0; num_passes = '0;
    repeat (3) @(negedge clk);
    areset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ap_done", 64'(ap_done), 64'd0);
    check("rst_step", 64'(step_count), 64'd0);
    check("rst_pass", 64'(pass_count), 64'd0);
    check("rst_cycle", cycle_count, 64'd0);
    check("rst_rd_addr", ctrl.rd_addr, 64'd0);
    check("rst_wr_addr", ctrl.wr_addr, 64'd0);
    check("rst_rd_size", 64'(ctrl.rd_size), 64'd0);

    // 1: four steps, one pass, 3-cycle master latency: 10 cycles per step.
    push_sweep(64'h1000, 64'h8000, 1, 4, 32'h100);
    exp_done.push_back('{step: 32'd4, pass: 16'd1, cyc: 64'd40});
    run(64'h1000, 64'h8000, 32'h100, 32'h400, 32'h100, 16'd1, 3, 41, 0);

    // 2: same region, three passes.
    push_sweep(64'h1000, 64'h8000, 3, 4, 32'h100);
    exp_done.push_back('{step: 32'd12, pass: 16'd3, cyc: 64'd120});
    run(64'h1000, 64'h8000, 32'h100, 32'h400, 32'h100, 16'd3, 3, 121, 0);

    // 3: transfer larger than region: no steps, done two cycles after start.
    exp_done.push_back('{step: 32'd0, pass: 16'd0, cyc: 64'd1});
    run(64'h4000, 64'hA000, 32'h100, 32'h100, 32'h200, 16'd1, 1, 2, 0);

    // 4: zero increment ends each pass after one step at offset 0.
    push_sweep(64'h2000, 64'h9000, 2, 1, 32'h0);
    exp_done.push_back('{step: 32'd2, pass: 16'd2, cyc: 64'd12});
    run(64'h2000, 64'h9000, 32'h0, 32'h1000, 32'h40, 16'd2, 1, 13, 0);

    // 5: spurious wr_done in every RD_WAIT and ap_start raised mid-run.
    spur = 1'b1;
    push_sweep(64'h1000, 64'h8000, 1, 4, 32'h100);
    exp_done.push_back('{step: 32'd4, pass: 16'd1, cyc: 64'd40});
    run(64'h1000, 64'h8000, 32'h100, 32'h400, 32'h100, 16'd1, 3, 41, 5);
    spur = 1'b0;

    // 6: reset while in WR_WAIT of the first step, then a fresh run.
    push_sweep(64'h1000, 64'h8000, 1, 1, 32'h100);
    rd_base = 64'h1000; wr_base = 64'h8000; addr_increment = 32'h100;
    mem_max_addr = 32'h400; xfer_size = 32'h100; num_passes = 16'd1;
    cur_lat = 3; cur_xfer = 32'h100;
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    repeat (6) @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_step", 64'(step_count), 64'd0);
    check("arst_pass", 64'(pass_count), 64'd0);
    check("arst_cycle", cycle_count, 64'd0);
    check("arst_rd_addr", ctrl.rd_addr, 64'd0);
    check("arst_wr_addr", ctrl.wr_addr, 64'd0);
    areset = 1'b0;
    repeat (2) @(negedge clk);
    push_sweep(64'h1000, 64'h8000, 1, 4, 32'h100);
    exp_done.push_back('{step: 32'd4, pass: 16'd1, cyc: 64'd40});
    run(64'h1000, 64'h8000, 32'h100, 32'h400, 32'h100, 16'd1, 3, 41, 0);

    repeat (5) @(negedge clk);
    check("rd_queue_left", 64'(exp_rd.size()), 64'd0);
    check("wr_queue_left", 64'(exp_wr.size()), 64'd0);
    check("done_queue_left", 64'(exp_done.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
